// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] prem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Widened by one bit so the shifted-in MSB of prem is never lost; borrow out means "too small".
  assign shifted   = {prem, q_msb};
  assign diff      = shifted - {1'b0, divisor};
  assign q_bit     = ~diff[WIDTH];
  assign prem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider with start/busy/done handshake for HI/LO.
// Define DIV_SIGNED_EN to honour the sign input (signed div); otherwise all operations are divu.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_prem;
  logic             step_bit;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] fin_quot;
  logic [WIDTH-1:0] fin_rem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem      (prem),
    .q_msb     (q[WIDTH-1]),
    .divisor   (dvs),
    .prem_next (step_prem),
    .q_bit     (step_bit)
  );

  // Result of the final iteration, taken straight off the step so DONE costs no extra cycle.
  assign q_fin = {q[WIDTH-2:0], step_bit};

`ifdef DIV_SIGNED_EN
  logic a_neg;
  logic b_neg;
  logic neg_q;
  logic neg_r;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign a_neg    = sign & A[WIDTH-1];
  assign b_neg    = sign & B[WIDTH-1];
  assign a_mag    = neg_if(A, a_neg);
  assign b_mag    = neg_if(B, b_neg);
  assign fin_quot = neg_if(q_fin, neg_q);
  assign fin_rem  = neg_if(step_prem, neg_r);
`else
  logic unused_sign;

  assign unused_sign = sign;
  assign a_mag       = A;
  assign b_mag       = B;
  assign fin_quot    = q_fin;
  assign fin_rem     = step_prem;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (B == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
              quot     <= '1;
              rem      <= A;
            end else begin
              state    <= RUN;
              div_zero <= 1'b0;
              prem     <= '0;
              q        <= a_mag;
              dvs      <= b_mag;
              cnt      <= CNT_W'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
`endif
            end
          end
        end
        RUN: begin
          prem <= step_prem;
          q    <= q_fin;
          if (cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
            quot  <= fin_quot;
            rem   <= fin_rem;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus randomized traffic against a cycle-count model.
module tb_div_seq;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sign;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         div_zero;

  div_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign     (sign),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  bit           m_busy, m_done, m_dz, p_dz;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  int           m_left;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
    longint sa, sb;
    if (b == '0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
      dz = 1'b0;
      if (s && SIGNED) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = W'(sa / sb);
        r  = W'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endtask

  // Model: accepted start -> result appears after W+1 cycles (1 for B==0), busy drops one cycle later.
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_q = '0; m_r = '0; m_left = 0;
      chk_en = 1'b1;
    end else if (m_busy) begin
      if (m_done) begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end
    end else if (start) begin
      ref_div(A, B, sign, p_q, p_r, p_dz);
      m_busy = 1'b1;
      m_dz   = 1'b0;
      m_left = (B == '0) ? 0 : W;
      if (m_left == 0) begin
        m_done = 1'b1; m_q = p_q; m_r = p_r; m_dz = p_dz;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", W'(busy), W'(m_busy));
      chk("done", W'(done), W'(m_done));
      chk("quot", quot, m_q);
      chk("rem", rem, m_r);
      chk("div_zero", W'(div_zero), W'(m_dz));
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(posedge clk); #2;
    start = 1'b1; A = a; B = b; sign = s;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base, output int cyc);
    cyc = -1;
    for (int n = base; n < base + 100; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = n;
        break;
      end
    end
    if (cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: done not seen within 100 cycles", name);
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input int ecyc, input logic [W-1:0] eq,
                       input logic [W-1:0] er, input logic edz);
    int c;
    start_op(a, b, s);
    wait_done(name, 1, c);
    chk({name, "_cycle"}, W'(c), W'(ecyc));
    chk({name, "_quot"}, quot, eq);
    chk({name, "_rem"}, rem, er);
    chk({name, "_dz"}, W'(div_zero), W'(edz));
  endtask

  initial begin
    int c;
    int seen;
    rst = 1'b1; start = 1'b0; sign = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dz", W'(div_zero), 0);

    do_op("udiv", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    chk("udiv_busy_low", W'(busy), 0);

    do_op("dz", 32'h1234, 32'h0, 1'b0, 1, 32'hFFFF_FFFF, 32'h1234, 1'b1);

    if (SIGNED) begin
      do_op("sdiv", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'h0, 1'b0);
    end else begin
      do_op("sdiv", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
      do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h0, 32'h8000_0000, 1'b0);
    end

    // A start pulse in cycle 10 must be dropped while the first divide runs.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #2 start = 1'b1; A = 32'd5; B = 32'd1; sign = 1'b0;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done("busy_ign", 11, c);
    chk("busy_ign_cycle", W'(c), 33);
    chk("busy_ign_quot", quot, 32'd14);
    chk("busy_ign_rem", rem, 32'd2);
    do_op("b2b", 32'd5, 32'd1, 1'b0, 33, 32'd5, 32'd0, 1'b0);

    // Reset in cycle 15 of a divide discards it.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (14) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", W'(busy), 0);
    chk("midrst_done", W'(done), 0);
    chk("midrst_quot", quot, 0);
    chk("midrst_rem", rem, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("midrst_no_done", W'(seen), 0);
    do_op("after_rst", 32'd9, 32'd3, 1'b0, 33, 32'd3, 32'd0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      rst   = ($urandom_range(0, 999) == 0);
      start = ($urandom_range(0, 3) == 0);
      sign  = 1'($urandom_range(0, 1));
      A     = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       B = '0;
        1:       B = $urandom_range(1, 15);
        2:       B = 32'hFFFF_FFFF;
        3:       B = $urandom >> $urandom_range(0, 31);
        default: B = $urandom;
      endcase
    end
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
